// File: rtl/wb_master_array.sv
// wb_master_array: NUM_CHANNELS independent Wishbone classic masters that write a word pattern, read it back
// and flag mismatches per channel. Optional ack timeout is enabled by defining WB_MASTER_ARRAY_TIMEOUT_EN.
module wb_master_array #(
    parameter int NUM_CHANNELS   = 2,
    parameter int BASE_ADDRESS   = 0,
    parameter int ADDR_STRIDE    = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_COUNT     = 16,
    parameter int SEED           = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    output logic                               done,
    output logic [NUM_CHANNELS-1:0]            err,
    input  logic [NUM_CHANNELS-1:0]            ack_i,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] dat_i,
    output logic [NUM_CHANNELS*ADDR_WIDTH-1:0] adr_o,
    output logic [NUM_CHANNELS-1:0]            cyc_o,
    output logic [NUM_CHANNELS-1:0]            stb_o,
    output logic [NUM_CHANNELS-1:0]            we_o,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] dat_o
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam int IDX_W = (DATA_COUNT > 1) ? $clog2(DATA_COUNT) : 1;

    logic [NUM_CHANNELS-1:0] in_done;
    assign done = &in_done;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [1:0]            state_q, state_d;
        logic [IDX_W-1:0]      idx_q, idx_d;
        logic                  err_q, err_d;
        logic                  active, last, tmo, xfer;
        logic [ADDR_WIDTH-1:0] adr;
        logic [DATA_WIDTH-1:0] pat;

        assign active = (state_q == S_WRITE) || (state_q == S_READ);
        assign last   = (idx_q == IDX_W'(DATA_COUNT - 1));
        // Sums wrap modulo the bus widths.
        assign adr = ADDR_WIDTH'(BASE_ADDRESS) + ADDR_WIDTH'(c * ADDR_STRIDE) + ADDR_WIDTH'(idx_q);
        assign pat = DATA_WIDTH'(SEED) + DATA_WIDTH'(c * DATA_COUNT) + DATA_WIDTH'(idx_q);

`ifdef WB_MASTER_ARRAY_TIMEOUT_EN
        localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
        logic [TMO_W-1:0] wait_q, wait_d;

        assign tmo = active && !ack_i[c] && (wait_q == TMO_W'(TIMEOUT_CYCLES - 1));

        always_comb begin
            wait_d = wait_q + 1'b1;
            if (!active || ack_i[c] || tmo) begin
                wait_d = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                wait_q <= '0;
            end else begin
                wait_q <= wait_d;
            end
        end
`else
        logic unused_timeout;
        assign unused_timeout = (TIMEOUT_CYCLES != 0);
        assign tmo = 1'b0;
`endif

        // A timed-out transfer advances exactly like an acked one.
        assign xfer = active && (ack_i[c] || tmo);

        always_comb begin
            state_d = state_q;
            idx_d   = idx_q;
            err_d   = err_q;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_WRITE;
                        idx_d   = '0;
                        err_d   = 1'b0;
                    end
                end
                S_WRITE, S_READ: begin
                    if (xfer) begin
                        if (state_q == S_READ && ack_i[c] && dat_i[c*DATA_WIDTH +: DATA_WIDTH] != pat) begin
                            err_d = 1'b1;
                        end
                        if (tmo) begin
                            err_d = 1'b1;
                        end
                        if (last) begin
                            idx_d   = '0;
                            state_d = (state_q == S_WRITE) ? S_READ : S_DONE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                state_q <= S_IDLE;
                idx_q   <= '0;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                idx_q   <= idx_d;
                err_q   <= err_d;
            end
        end

        assign in_done[c] = (state_q == S_DONE);
        assign err[c]     = err_q;
        assign cyc_o[c]   = active;
        assign stb_o[c]   = active;
        assign we_o[c]    = (state_q == S_WRITE);
        assign adr_o[c*ADDR_WIDTH +: ADDR_WIDTH] = active ? adr : '0;
        assign dat_o[c*DATA_WIDTH +: DATA_WIDTH] = (state_q == S_WRITE) ? pat : '0;
    end
endmodule
